// File: rtl/soc_ahb_pkg.sv
// -----------------------------------------------------------------------------
// soc_ahb_pkg
// Shared AHB-Lite definitions for the SoC bus fabric.
//   - HTRANS and HBURST encodings
//   - bus owner enumeration used by the master arbiter
//   - legal range of the arbiter's IDLE_RELEASE parking threshold
// -----------------------------------------------------------------------------
package soc_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;

   typedef enum logic {
      OWN_M0 = 1'b0,
      OWN_M1 = 1'b1
   } owner_t;

   // The idle counter is 4 bits wide, so the parking threshold must fit in it.
   localparam int IDLE_RELEASE_MIN = 1;
   localparam int IDLE_RELEASE_MAX = 15;
   localparam int IDLE_CNT_W       = 4;

endpackage

// File: rtl/ahb_lite_master_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_lite_master_arbiter
// Two-master AHB-Lite arbiter. Master 0 (CPU) is the default/parking owner,
// master 1 (DMA/accelerator) takes the bus when it requests at a transfer
// boundary. Ownership only changes when the current owner's address phase is
// IDLE, the bus is ready and no locked sequence is in progress, so bursts and
// locked sequences are never split.
//
// Ports
//   HCLK, HRESET            clock, synchronous active-high reset
//   H*_M0 / H*_M1           address/control/write data from each master
//   HREADY_M0/M1            per-master ready (owner mirrors HREADY,
//                           non-owner stalls any NONSEQ/SEQ it issues)
//   HRDATA_M, HRESP_M       slave response, broadcast to both masters
//   HADDR..HWDATA           muxed bus-side signals toward the slaves
//   HMASTER                 current address-phase owner
//   HREADY, HRDATA, HRESP   muxed slave response
// -----------------------------------------------------------------------------
module ahb_lite_master_arbiter
   import soc_ahb_pkg::*;
#(
   parameter int W            = 32,
   parameter int IDLE_RELEASE = 4
) (
   input  logic         HCLK,
   input  logic         HRESET,

   input  logic [W-1:0] HADDR_M0,
   input  logic [1:0]   HTRANS_M0,
   input  logic         HWRITE_M0,
   input  logic [2:0]   HSIZE_M0,
   input  logic [2:0]   HBURST_M0,
   input  logic [3:0]   HPROT_M0,
   input  logic         HMASTLOCK_M0,
   input  logic [W-1:0] HWDATA_M0,
   output logic         HREADY_M0,

   input  logic [W-1:0] HADDR_M1,
   input  logic [1:0]   HTRANS_M1,
   input  logic         HWRITE_M1,
   input  logic [2:0]   HSIZE_M1,
   input  logic [2:0]   HBURST_M1,
   input  logic [3:0]   HPROT_M1,
   input  logic         HMASTLOCK_M1,
   input  logic [W-1:0] HWDATA_M1,
   output logic         HREADY_M1,

   output logic [W-1:0] HRDATA_M,
   output logic         HRESP_M,

   output logic [W-1:0] HADDR,
   output logic [1:0]   HTRANS,
   output logic         HWRITE,
   output logic [2:0]   HSIZE,
   output logic [2:0]   HBURST,
   output logic [3:0]   HPROT,
   output logic         HMASTLOCK,
   output logic [W-1:0] HWDATA,
   output logic         HMASTER,

   input  logic         HREADY,
   input  logic [W-1:0] HRDATA,
   input  logic         HRESP
);

   if (IDLE_RELEASE < IDLE_RELEASE_MIN || IDLE_RELEASE > IDLE_RELEASE_MAX) begin : g_bad_idle_release
      $error("ahb_lite_master_arbiter: IDLE_RELEASE must be within 1..15");
   end

   // Parking happens on the arbitration point that completes the
   // IDLE_RELEASE-th consecutive IDLE, i.e. when the count already holds
   // IDLE_RELEASE-1 completed IDLEs.
   localparam logic [IDLE_CNT_W-1:0] PARK_CNT  = IDLE_CNT_W'(IDLE_RELEASE - 1);
   localparam logic [IDLE_CNT_W-1:0] IDLE_SAT  = '1;

   owner_t                  addr_owner, addr_owner_nxt;
   owner_t                  data_owner, data_owner_nxt;
   logic                    lock_hold,  lock_hold_nxt;
   logic [IDLE_CNT_W-1:0]   idle_cnt,   idle_cnt_nxt;

   logic [1:0]              owner_htrans;
   logic                    owner_lock;
   logic                    owner_idle;
   logic                    arb_point;
   logic                    park;

   // Owner's view, used for arbitration and lock tracking.
   always_comb begin
      owner_htrans = HTRANS_M0;
      owner_lock   = HMASTLOCK_M0;
      if (addr_owner == OWN_M1) begin
         owner_htrans = HTRANS_M1;
         owner_lock   = HMASTLOCK_M1;
      end
      owner_idle = (owner_htrans == HTRANS_IDLE);
      // BUSY/NONSEQ/SEQ are all inside a transfer or burst; only IDLE is a
      // safe handover point.
      arb_point  = HREADY && owner_idle && !lock_hold;
      park       = (idle_cnt >= PARK_CNT);
   end

   // Ownership FSM next state.
   always_comb begin
      addr_owner_nxt = addr_owner;
      case (addr_owner)
         OWN_M0: begin
            if (arb_point && HTRANS_M1[1]) begin
               addr_owner_nxt = OWN_M1;
            end
         end
         OWN_M1: begin
            if (arb_point && (HTRANS_M0[1] || park)) begin
               addr_owner_nxt = OWN_M0;
            end
         end
         default: addr_owner_nxt = OWN_M0;
      endcase
   end

   // Data owner, lock tracking and M1 idle counting.
   always_comb begin
      data_owner_nxt = data_owner;
      lock_hold_nxt  = lock_hold;
      idle_cnt_nxt   = idle_cnt;

      if (HREADY) begin
         data_owner_nxt = addr_owner;
         // An IDLE that still carries HMASTLOCK keeps the lock; only an
         // unlocked IDLE ends the locked sequence.
         if (owner_lock) begin
            lock_hold_nxt = 1'b1;
         end else if (owner_idle) begin
            lock_hold_nxt = 1'b0;
         end
      end

      if (addr_owner_nxt != addr_owner) begin
         idle_cnt_nxt = '0;
      end else if (addr_owner == OWN_M1 && HREADY) begin
         if (HTRANS_M1 != HTRANS_IDLE) begin
            idle_cnt_nxt = '0;
         end else if (arb_point && idle_cnt != IDLE_SAT) begin
            idle_cnt_nxt = idle_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_owner <= OWN_M0;
         data_owner <= OWN_M0;
         lock_hold  <= 1'b0;
         idle_cnt   <= '0;
      end else begin
         addr_owner <= addr_owner_nxt;
         data_owner <= data_owner_nxt;
         lock_hold  <= lock_hold_nxt;
         idle_cnt   <= idle_cnt_nxt;
      end
   end

   // Bus-side multiplexing and per-master ready.
   always_comb begin
      HADDR     = HADDR_M0;
      HTRANS    = HTRANS_M0;
      HWRITE    = HWRITE_M0;
      HSIZE     = HSIZE_M0;
      HBURST    = HBURST_M0;
      HPROT     = HPROT_M0;
      HMASTLOCK = HMASTLOCK_M0;
      if (addr_owner == OWN_M1) begin
         HADDR     = HADDR_M1;
         HTRANS    = HTRANS_M1;
         HWRITE    = HWRITE_M1;
         HSIZE     = HSIZE_M1;
         HBURST    = HBURST_M1;
         HPROT     = HPROT_M1;
         HMASTLOCK = HMASTLOCK_M1;
      end

      // Write data belongs to the data phase, which lags the address phase.
      HWDATA = (data_owner == OWN_M1) ? HWDATA_M1 : HWDATA_M0;

      // A non-owner issuing IDLE may complete immediately; anything else is
      // held until it owns the bus.
      HREADY_M0 = (addr_owner == OWN_M0) ? HREADY : ~HTRANS_M0[1];
      HREADY_M1 = (addr_owner == OWN_M1) ? HREADY : ~HTRANS_M1[1];
      HMASTER   = (addr_owner == OWN_M1);

      if (HRESET) begin
         HTRANS    = HTRANS_IDLE;
         HREADY_M0 = 1'b1;
         HREADY_M1 = 1'b1;
         HMASTER   = 1'b0;
      end

      HRDATA_M = HRDATA;
      HRESP_M  = HRESP;
   end

endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Testbench for ahb_lite_master_arbiter: directed scenarios with literal
// expectations, plus a cycle-by-cycle comparison against an ownership model.
module tb_ahb_lite_master_arbiter;
   import soc_ahb_pkg::*;

   localparam int W  = 32;
   localparam int IR = 4;

   logic         HCLK;
   logic         HRESET;
   logic [W-1:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
   logic [1:0]   HTRANS_M0, HTRANS_M1;
   logic         HWRITE_M0, HWRITE_M1, HMASTLOCK_M0, HMASTLOCK_M1;
   logic [2:0]   HSIZE_M0, HSIZE_M1, HBURST_M0, HBURST_M1;
   logic [3:0]   HPROT_M0, HPROT_M1;
   logic         HREADY_M0, HREADY_M1;
   logic [W-1:0] HRDATA_M;
   logic         HRESP_M;
   logic [W-1:0] HADDR, HWDATA;
   logic [1:0]   HTRANS;
   logic         HWRITE, HMASTLOCK, HMASTER;
   logic [2:0]   HSIZE, HBURST;
   logic [3:0]   HPROT;
   logic         HREADY;
   logic [W-1:0] HRDATA;
   logic         HRESP;

   int errors = 0;
   int checks = 0;

   ahb_lite_master_arbiter #(.W(W), .IDLE_RELEASE(IR)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
      .HSIZE_M0(HSIZE_M0), .HBURST_M0(HBURST_M0), .HPROT_M0(HPROT_M0),
      .HMASTLOCK_M0(HMASTLOCK_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0),
      .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
      .HSIZE_M1(HSIZE_M1), .HBURST_M1(HBURST_M1), .HPROT_M1(HPROT_M1),
      .HMASTLOCK_M1(HMASTLOCK_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
      .HRDATA_M(HRDATA_M), .HRESP_M(HRESP_M),
      .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
      .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HMASTER(HMASTER),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_m0(input logic [1:0] tr, input logic [31:0] ad, input logic wr,
                           input logic lk, input logic [31:0] wd);
      HTRANS_M0 = tr; HADDR_M0 = ad; HWRITE_M0 = wr; HMASTLOCK_M0 = lk; HWDATA_M0 = wd;
   endtask

   task automatic drive_m1(input logic [1:0] tr, input logic [31:0] ad, input logic wr,
                           input logic lk, input logic [31:0] wd);
      HTRANS_M1 = tr; HADDR_M1 = ad; HWRITE_M1 = wr; HMASTLOCK_M1 = lk; HWDATA_M1 = wd;
   endtask

   // ---------------------------------------------------------------------
   // Ownership model: who owns the address phase, who owns the data phase,
   // whether a locked sequence is open, and how many IDLEs M1 has completed
   // in a row while owning the bus.
   // ---------------------------------------------------------------------
   bit m_on = 1'b0;
   bit m_own, m_dat, m_lock;
   int m_idles;

   always @(posedge HCLK) begin
      logic [1:0] otr;
      bit         olk, boundary, nxt;
      if (HRESET) begin
         m_on = 1'b1; m_own = 1'b0; m_dat = 1'b0; m_lock = 1'b0; m_idles = 0;
      end else if (HREADY) begin
         otr      = m_own ? HTRANS_M1 : HTRANS_M0;
         olk      = m_own ? HMASTLOCK_M1 : HMASTLOCK_M0;
         boundary = (otr == HTRANS_IDLE) && !m_lock;
         nxt      = m_own;
         if (boundary) begin
            if (!m_own && HTRANS_M1[1]) nxt = 1'b1;
            else if (m_own && (HTRANS_M0[1] || (m_idles + 1 >= IR))) nxt = 1'b0;
         end
         if (m_own) begin
            if (HTRANS_M1 != HTRANS_IDLE) m_idles = 0;
            else if (boundary) m_idles = m_idles + 1;
         end
         if (nxt != m_own) m_idles = 0;
         m_dat = m_own;
         m_own = nxt;
         if (olk) m_lock = 1'b1;
         else if (otr == HTRANS_IDLE) m_lock = 1'b0;
      end
   end

   always @(negedge HCLK) begin
      if (m_on) begin
         chk("m_hmaster", 32'(HMASTER), HRESET ? 32'd0 : 32'(m_own));
         chk("m_htrans", 32'(HTRANS), HRESET ? 32'd0 : 32'(m_own ? HTRANS_M1 : HTRANS_M0));
         chk("m_haddr", HADDR, m_own ? HADDR_M1 : HADDR_M0);
         chk("m_hwrite", 32'(HWRITE), 32'(m_own ? HWRITE_M1 : HWRITE_M0));
         chk("m_hsize", 32'(HSIZE), 32'(m_own ? HSIZE_M1 : HSIZE_M0));
         chk("m_hburst", 32'(HBURST), 32'(m_own ? HBURST_M1 : HBURST_M0));
         chk("m_hprot", 32'(HPROT), 32'(m_own ? HPROT_M1 : HPROT_M0));
         chk("m_hmastlock", 32'(HMASTLOCK), 32'(m_own ? HMASTLOCK_M1 : HMASTLOCK_M0));
         chk("m_hwdata", HWDATA, m_dat ? HWDATA_M1 : HWDATA_M0);
         chk("m_hready_m0", 32'(HREADY_M0),
             HRESET ? 32'd1 : (!m_own ? 32'(HREADY) : 32'(!HTRANS_M0[1])));
         chk("m_hready_m1", 32'(HREADY_M1),
             HRESET ? 32'd1 : (m_own ? 32'(HREADY) : 32'(!HTRANS_M1[1])));
         chk("m_hrdata_m", HRDATA_M, HRDATA);
         chk("m_hresp_m", 32'(HRESP_M), 32'(HRESP));
      end
   end

   localparam logic [1:0]  BUR_TR [6] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY,
                                          HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE};
   localparam logic [31:0] BUR_AD [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'hC, 32'hC};
   localparam logic [1:0]  LCK_TR [5] = '{HTRANS_NONSEQ, HTRANS_IDLE, HTRANS_NONSEQ,
                                          HTRANS_IDLE, HTRANS_IDLE};
   localparam logic        LCK_WR [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic        LCK_LK [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

   initial begin
      HRESET = 1'b1; HREADY = 1'b1; HRDATA = '0; HRESP = 1'b0;
      HSIZE_M0 = 3'b010; HBURST_M0 = HBURST_SINGLE; HPROT_M0 = 4'h3;
      HSIZE_M1 = 3'b010; HBURST_M1 = HBURST_SINGLE; HPROT_M1 = 4'h1;
      drive_m0(HTRANS_NONSEQ, 32'h2000_0000, 1'b0, 1'b0, 32'h0);
      drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);

      // Reset held for three edges with M0 requesting.
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("rst_htrans", 32'(HTRANS), 32'd0);
         chk("rst_hmaster", 32'(HMASTER), 32'd0);
         chk("rst_hready_m0", 32'(HREADY_M0), 32'd1);
         chk("rst_hready_m1", 32'(HREADY_M1), 32'd1);
         step();
      end
      HRESET = 1'b0;
      #2;
      chk("post_rst_haddr", HADDR, 32'h2000_0000);
      chk("post_rst_htrans", 32'(HTRANS), 32'(HTRANS_NONSEQ));

      // Handover to M1 while M0 is IDLE.
      step();
      drive_m0(HTRANS_IDLE, 32'h2000_0000, 1'b0, 1'b0, 32'h0);
      drive_m1(HTRANS_NONSEQ, 32'h4000_0000, 1'b1, 1'b0, 32'hDEAD_BEEF);
      #2;
      chk("ho_stall_m1", 32'(HREADY_M1), 32'd0);
      chk("ho_hmaster_before", 32'(HMASTER), 32'd0);
      step();
      #2;
      chk("ho_hmaster", 32'(HMASTER), 32'd1);
      chk("ho_haddr", HADDR, 32'h4000_0000);
      chk("ho_hready_m1", 32'(HREADY_M1), 32'd1);
      step();
      drive_m1(HTRANS_IDLE, 32'h4000_0000, 1'b0, 1'b0, 32'hDEAD_BEEF);
      #2;
      chk("ho_hwdata", HWDATA, 32'hDEAD_BEEF);

      // M1 read with three wait states while M0 requests.
      step();
      drive_m1(HTRANS_NONSEQ, 32'h4000_0004, 1'b0, 1'b0, 32'h0);
      #2;
      chk("ws_haddr", HADDR, 32'h4000_0004);
      step();
      drive_m1(HTRANS_IDLE, 32'h4000_0004, 1'b0, 1'b0, 32'h0);
      drive_m0(HTRANS_NONSEQ, 32'h2000_0020, 1'b0, 1'b0, 32'h0);
      HREADY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) step();
         #2;
         chk("ws_hmaster", 32'(HMASTER), 32'd1);
         chk("ws_hready_m1", 32'(HREADY_M1), 32'd0);
         chk("ws_hready_m0", 32'(HREADY_M0), 32'd0);
      end
      step();
      HREADY = 1'b1; HRDATA = 32'h1234_5678;
      #2;
      chk("ws_hrdata_m", HRDATA_M, 32'h1234_5678);
      chk("ws_hready_m1_done", 32'(HREADY_M1), 32'd1);
      chk("ws_hmaster_done", 32'(HMASTER), 32'd1);
      step();
      HRDATA = '0;
      #2;
      chk("ws_back_to_m0", 32'(HMASTER), 32'd0);
      chk("ws_m0_haddr", HADDR, 32'h2000_0020);

      // M1 INCR4 burst with a BUSY beat; M0 must wait for the closing IDLE.
      step();
      drive_m0(HTRANS_IDLE, 32'h2000_0020, 1'b0, 1'b0, 32'h0);
      drive_m1(HTRANS_NONSEQ, 32'h0, 1'b0, 1'b0, 32'h0);
      HBURST_M1 = HBURST_INCR4;
      #2;
      chk("bu_stall_m1", 32'(HREADY_M1), 32'd0);
      for (int i = 0; i < 6; i++) begin
         step();
         drive_m1(BUR_TR[i], BUR_AD[i], 1'b0, 1'b0, 32'h0);
         drive_m0(HTRANS_NONSEQ, 32'h2000_0030, 1'b0, 1'b0, 32'h0);
         #2;
         chk("bu_hmaster", 32'(HMASTER), 32'd1);
         chk("bu_m0_stall", 32'(HREADY_M0), 32'd0);
      end
      step();
      HBURST_M1 = HBURST_SINGLE;
      #2;
      chk("bu_hmaster_after", 32'(HMASTER), 32'd0);
      chk("bu_m0_haddr", HADDR, 32'h2000_0030);
      chk("bu_m0_ready", 32'(HREADY_M0), 32'd1);

      // M0 locked read-IDLE-write; M1 requests throughout.
      for (int i = 0; i < 5; i++) begin
         step();
         drive_m0(LCK_TR[i], 32'h2000_0010, LCK_WR[i], LCK_LK[i], 32'h5555_0000);
         drive_m1(HTRANS_NONSEQ, 32'h4000_0008, 1'b1, 1'b0, 32'hCAFE_F00D);
         #2;
         chk("lk_hmaster", 32'(HMASTER), 32'd0);
         chk("lk_m1_stall", 32'(HREADY_M1), 32'd0);
      end
      step();
      #2;
      chk("lk_hmaster_after", 32'(HMASTER), 32'd1);
      chk("lk_m1_haddr", HADDR, 32'h4000_0008);

      // Parking after IR completed IDLEs by M1, with an error response seen.
      step();
      drive_m1(HTRANS_IDLE, 32'h4000_0008, 1'b0, 1'b0, 32'hCAFE_F00D);
      for (int k = 0; k < IR; k++) begin
         if (k > 0) step();
         HRESP = (k == 2);
         #2;
         chk("pk_hmaster", 32'(HMASTER), 32'd1);
      end
      step();
      HRESP = 1'b0;
      drive_m0(HTRANS_NONSEQ, 32'h2000_0040, 1'b1, 1'b0, 32'h0);
      #2;
      chk("pk_hmaster_parked", 32'(HMASTER), 32'd0);
      chk("pk_m0_no_stall", 32'(HREADY_M0), 32'd1);
      chk("pk_m0_haddr", HADDR, 32'h2000_0040);

      // Reset asserted mid-transfer with both masters requesting.
      step();
      drive_m0(HTRANS_NONSEQ, 32'h2000_0044, 1'b0, 1'b0, 32'h0);
      drive_m1(HTRANS_NONSEQ, 32'h4000_0010, 1'b0, 1'b0, 32'h0);
      HRESET = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i > 0) step();
         #2;
         chk("rst2_htrans", 32'(HTRANS), 32'd0);
         chk("rst2_hmaster", 32'(HMASTER), 32'd0);
         chk("rst2_hready_m1", 32'(HREADY_M1), 32'd1);
      end
      step();
      HRESET = 1'b0;
      #2;
      chk("rst2_haddr", HADDR, 32'h2000_0044);
      chk("rst2_m1_stall", 32'(HREADY_M1), 32'd0);
      step();
      drive_m0(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
      drive_m1(HTRANS_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
